// File: rtl/four_bit_decade_down_counter.sv
// Cascaded BCD down counter with synchronous preset load, enable and a registered underflow borrow.
// Build option AUTO_RELOAD_EN: when defined, underflow reloads the last preset; otherwise it wraps to all nines.
module four_bit_decade_down_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   count,
  output logic                  out1,
  output logic                  out2,
  output logic                  out3,
  output logic                  out4,
  output logic                  zero,
  output logic                  borrow
);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic [4*DIGITS-1:0] preset_q, preset_d;
  logic                borrow_q, borrow_d;

  logic [4*DIGITS-1:0] din_sane;
  logic [4*DIGITS-1:0] dec_val;
  logic [4*DIGITS-1:0] nines;
  logic                chain;
  logic                underflow;

  // Digits above 9 are clamped so the count register only ever holds valid BCD.
  always_comb begin
    din_sane = '0;
    nines    = '0;
    for (int k = 0; k < DIGITS; k++) begin
      din_sane[4*k +: 4] = (din[4*k +: 4] > 4'd9) ? 4'd9 : din[4*k +: 4];
      nines[4*k +: 4]    = 4'd9;
    end
  end

  // Ripple the decrement upward: a digit only moves when every lower digit was 0.
  always_comb begin
    dec_val = count_q;
    chain   = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (chain) begin
        if (count_q[4*k +: 4] == 4'd0) begin
          dec_val[4*k +: 4] = 4'd9;
        end else begin
          dec_val[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
          chain             = 1'b0;
        end
      end
    end
  end

  assign underflow = (count_q == '0);

  always_comb begin
    count_d  = count_q;
    preset_d = preset_q;
    borrow_d = 1'b0;
    if (load) begin
      count_d  = din_sane;
      preset_d = din_sane;
    end else if (en) begin
      if (underflow) begin
        borrow_d = 1'b1;
`ifdef AUTO_RELOAD_EN
        count_d  = preset_q;
`else
        count_d  = nines;
`endif
      end else begin
        count_d = dec_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      preset_q <= '0;
      borrow_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      preset_q <= preset_d;
      borrow_q <= borrow_d;
    end
  end

  assign count  = count_q;
  assign out1   = count_q[0];
  assign out2   = count_q[1];
  assign out3   = count_q[2];
  assign out4   = count_q[3];
  assign zero   = (count_q == '0);
  assign borrow = borrow_q;

endmodule
